// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter that lets the CPU load/store unit and the host bridge share the
// single data-memory port, one word access at a time, with registered responses.
module data_memory_arbiter #(
    parameter int MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        cpu_req_valid,
    output logic        cpu_req_ready,
    input  logic [31:0] cpu_req_addr,
    input  logic [31:0] cpu_req_wdata,
    input  logic        cpu_req_we,
    output logic        cpu_rsp_valid,
    input  logic        cpu_rsp_ready,
    output logic [31:0] cpu_rsp_rdata,
    output logic        cpu_rsp_err,

    input  logic        host_req_valid,
    output logic        host_req_ready,
    input  logic [31:0] host_req_addr,
    input  logic [31:0] host_req_wdata,
    input  logic        host_req_we,
    output logic        host_rsp_valid,
    input  logic        host_rsp_ready,
    output logic [31:0] host_rsp_rdata,
    output logic        host_rsp_err,

    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_read_data,

    output logic        busy,
    output logic [1:0]  dbg_state
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // a response transfers on a rising edge where rsp_valid && rsp_ready.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic OWN_CPU  = 1'b0;
    localparam logic OWN_HOST = 1'b1;

    localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

    logic [1:0]  state;
    logic        owner;
    logic        last_grant;
    logic        we_q;
    logic        err_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    logic        grant_cpu;
    logic        grant_host;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_we;
    logic        resp_done;

    // On a tie the requester that did not win last time gets the port.
    always_comb begin
        grant_cpu  = 1'b0;
        grant_host = 1'b0;
        if (state == ST_IDLE) begin
            if (cpu_req_valid && (!host_req_valid || last_grant == OWN_HOST)) begin
                grant_cpu = 1'b1;
            end else if (host_req_valid) begin
                grant_host = 1'b1;
            end
        end
    end

    assign sel_addr  = grant_host ? host_req_addr  : cpu_req_addr;
    assign sel_wdata = grant_host ? host_req_wdata : cpu_req_wdata;
    assign sel_we    = grant_host ? host_req_we    : cpu_req_we;

    assign resp_done = (state == ST_RESP) &&
                       ((owner == OWN_CPU) ? cpu_rsp_ready : host_rsp_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            owner      <= OWN_CPU;
            last_grant <= OWN_HOST;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            rdata_q    <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_cpu || grant_host) begin
                        owner      <= grant_host;
                        last_grant <= grant_host;
                        addr_q     <= sel_addr;
                        wdata_q    <= sel_wdata;
                        we_q       <= sel_we;
                        // Unsigned compare: addresses near 2^32 must not wrap into range.
                        err_q      <= (sel_addr[1:0] != 2'b00) || (sel_addr > LAST_WORD);
                        state      <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    rdata_q <= (!we_q && !err_q) ? mem_read_data : 32'h0;
                    state   <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign cpu_req_ready  = grant_cpu;
    assign host_req_ready = grant_host;

    assign mem_address    = addr_q;
    assign mem_write_data = wdata_q;
    assign mem_write      = (state == ST_ACCESS) &&  we_q && !err_q;
    assign mem_read       = (state == ST_ACCESS) && !we_q && !err_q;

    assign cpu_rsp_valid  = (state == ST_RESP) && (owner == OWN_CPU);
    assign host_rsp_valid = (state == ST_RESP) && (owner == OWN_HOST);
    assign cpu_rsp_rdata  = cpu_rsp_valid  ? rdata_q : 32'h0;
    assign host_rsp_rdata = host_rsp_valid ? rdata_q : 32'h0;
    assign cpu_rsp_err    = cpu_rsp_valid  && err_q;
    assign host_rsp_err   = host_rsp_valid && err_q;

    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter: vector table of single transactions plus
// hand-written sequences for arbitration, backpressure and asynchronous reset.
module tb_data_memory_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req_valid, cpu_req_ready, cpu_req_we;
    logic [31:0] cpu_req_addr, cpu_req_wdata;
    logic        cpu_rsp_valid, cpu_rsp_ready, cpu_rsp_err;
    logic [31:0] cpu_rsp_rdata;
    logic        host_req_valid, host_req_ready, host_req_we;
    logic [31:0] host_req_addr, host_req_wdata;
    logic        host_rsp_valid, host_rsp_ready, host_rsp_err;
    logic [31:0] host_rsp_rdata;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_write, mem_read, busy;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;

    logic [31:0] mem_model [0:1023] = '{default: 32'h0};

    always #5 clk = ~clk;

    data_memory_arbiter #(.MEM_BYTES(4096)) dut (
        .clk(clk), .reset(reset),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata), .cpu_req_we(cpu_req_we),
        .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_ready(cpu_rsp_ready),
        .cpu_rsp_rdata(cpu_rsp_rdata), .cpu_rsp_err(cpu_rsp_err),
        .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
        .host_req_addr(host_req_addr), .host_req_wdata(host_req_wdata), .host_req_we(host_req_we),
        .host_rsp_valid(host_rsp_valid), .host_rsp_ready(host_rsp_ready),
        .host_rsp_rdata(host_rsp_rdata), .host_rsp_err(host_rsp_err),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data),
        .busy(busy), .dbg_state(dbg_state)
    );

    // Data memory stand-in: combinational read, write on the rising edge.
    assign mem_read_data = mem_model[mem_address[11:2]];
    always @(posedge clk) begin
        if (mem_write) mem_model[mem_address[11:2]] <= mem_write_data;
        if (mem_write) wr_cnt <= wr_cnt + 1;
        if (mem_read)  rd_cnt <= rd_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          host;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs [10];

    task automatic run_txn(input vec_t v, input int idx);
        int w0, r0;
        @(negedge clk);
        if (v.host) begin
            host_req_valid = 1'b1; host_req_addr = v.addr; host_req_wdata = v.wdata; host_req_we = v.we;
        end else begin
            cpu_req_valid = 1'b1; cpu_req_addr = v.addr; cpu_req_wdata = v.wdata; cpu_req_we = v.we;
        end
        #1;
        chk($sformatf("v%0d_req_ready", idx), v.host ? host_req_ready : cpu_req_ready, 32'd1);
        chk($sformatf("v%0d_other_ready", idx), v.host ? cpu_req_ready : host_req_ready, 32'd0);
        w0 = wr_cnt; r0 = rd_cnt;
        @(negedge clk);
        cpu_req_valid = 1'b0; host_req_valid = 1'b0;
        #1;
        chk($sformatf("v%0d_mem_write", idx), mem_write, {31'd0, v.we & ~v.exp_err});
        chk($sformatf("v%0d_mem_read", idx), mem_read, {31'd0, ~v.we & ~v.exp_err});
        chk($sformatf("v%0d_mem_address", idx), mem_address, v.addr);
        chk($sformatf("v%0d_early_rsp", idx), cpu_rsp_valid | host_rsp_valid, 32'd0);
        @(negedge clk);
        #1;
        chk($sformatf("v%0d_rsp_valid", idx), v.host ? host_rsp_valid : cpu_rsp_valid, 32'd1);
        chk($sformatf("v%0d_other_rsp", idx), v.host ? cpu_rsp_valid : host_rsp_valid, 32'd0);
        chk($sformatf("v%0d_rdata", idx), v.host ? host_rsp_rdata : cpu_rsp_rdata, v.exp_rdata);
        chk($sformatf("v%0d_err", idx), v.host ? host_rsp_err : cpu_rsp_err, {31'd0, v.exp_err});
        chk($sformatf("v%0d_write_count", idx), wr_cnt - w0, {31'd0, v.we & ~v.exp_err});
        chk($sformatf("v%0d_read_count", idx), rd_cnt - r0, {31'd0, ~v.we & ~v.exp_err});
        @(negedge clk);
        #1;
        chk($sformatf("v%0d_idle", idx), busy, 32'd0);
    endtask

    task automatic drain(input string name);
        int c;
        c = 0;
        while (busy && c < 20) begin
            @(negedge clk); #1; c++;
        end
        chk({name, "_drain"}, busy, 32'd0);
    endtask

    initial begin
        int grants, rsps;

        vecs[0] = '{host: 0, we: 1, addr: 32'h0000_0100, wdata: 32'hDEAD_BEEF, exp_rdata: 32'h0, exp_err: 0};
        vecs[1] = '{host: 0, we: 0, addr: 32'h0000_0100, wdata: 32'h0, exp_rdata: 32'hDEAD_BEEF, exp_err: 0};
        vecs[2] = '{host: 1, we: 0, addr: 32'h0000_0FFD, wdata: 32'h0, exp_rdata: 32'h0, exp_err: 1};
        vecs[3] = '{host: 1, we: 0, addr: 32'h0000_1000, wdata: 32'h0, exp_rdata: 32'h0, exp_err: 1};
        vecs[4] = '{host: 0, we: 1, addr: 32'h0000_0FFC, wdata: 32'h1234_5678, exp_rdata: 32'h0, exp_err: 0};
        vecs[5] = '{host: 1, we: 0, addr: 32'h0000_0FFC, wdata: 32'h0, exp_rdata: 32'h1234_5678, exp_err: 0};
        vecs[6] = '{host: 0, we: 0, addr: 32'hFFFF_FFFC, wdata: 32'h0, exp_rdata: 32'h0, exp_err: 1};
        vecs[7] = '{host: 0, we: 1, addr: 32'h0000_1002, wdata: 32'hBAD0_BAD0, exp_rdata: 32'h0, exp_err: 1};
        vecs[8] = '{host: 0, we: 1, addr: 32'h0000_0204, wdata: 32'h0000_BEEF, exp_rdata: 32'h0, exp_err: 0};
        vecs[9] = '{host: 1, we: 1, addr: 32'h0000_0200, wdata: 32'hA5A5_0001, exp_rdata: 32'h0, exp_err: 0};

        reset = 1'b1;
        cpu_req_valid = 0; cpu_req_addr = 0; cpu_req_wdata = 0; cpu_req_we = 0; cpu_rsp_ready = 1;
        host_req_valid = 0; host_req_addr = 0; host_req_wdata = 0; host_req_we = 0; host_rsp_ready = 1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_busy", busy, 32'd0);
        chk("reset_mem_strobes", {mem_write, mem_read}, 32'd0);
        chk("reset_mem_address", mem_address, 32'h0);
        chk("reset_mem_wdata", mem_write_data, 32'h0);
        chk("reset_rsp_valid", {cpu_rsp_valid, host_rsp_valid}, 32'd0);
        chk("reset_rsp_rdata", cpu_rsp_rdata | host_rsp_rdata, 32'h0);
        chk("reset_rsp_err", {cpu_rsp_err, host_rsp_err}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) run_txn(vecs[i], i);

        // Both requesters valid every cycle; last grant was the host, so CPU leads.
        @(negedge clk);
        cpu_req_valid = 1; cpu_req_we = 0; cpu_req_addr = 32'h204;
        host_req_valid = 1; host_req_we = 0; host_req_addr = 32'h200;
        grants = 0; rsps = 0;
        for (int c = 0; c < 40 && (grants < 4 || rsps < 4); c++) begin
            #1;
            if (cpu_req_ready || host_req_ready) begin
                chk($sformatf("alt_grant%0d_host", grants), {31'd0, host_req_ready}, grants % 2);
                chk($sformatf("alt_grant%0d_single", grants), cpu_req_ready & host_req_ready, 32'd0);
                grants++;
            end
            if (cpu_rsp_valid) begin
                chk("alt_cpu_rdata", cpu_rsp_rdata, 32'h0000_BEEF);
                chk("alt_cpu_rsp_exclusive", host_rsp_valid, 32'd0);
                rsps++;
            end
            if (host_rsp_valid) begin
                chk("alt_host_rdata", host_rsp_rdata, 32'hA5A5_0001);
                rsps++;
            end
            @(negedge clk);
            if (grants >= 4) begin
                cpu_req_valid = 0; host_req_valid = 0;
            end
        end
        chk("alt_grant_count", grants, 32'd4);
        chk("alt_rsp_count", rsps, 32'd4);
        drain("alt");

        // CPU stalls its response for 5 cycles while the host waits.
        @(negedge clk);
        cpu_req_valid = 1; cpu_req_we = 0; cpu_req_addr = 32'h100; cpu_rsp_ready = 0;
        host_req_valid = 1; host_req_we = 0; host_req_addr = 32'h200;
        #1;
        chk("bp_cpu_grant", cpu_req_ready, 32'd1);
        chk("bp_host_wait", host_req_ready, 32'd0);
        @(negedge clk);
        cpu_req_valid = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            chk($sformatf("bp_hold%0d_valid", c), cpu_rsp_valid, 32'd1);
            chk($sformatf("bp_hold%0d_rdata", c), cpu_rsp_rdata, 32'hDEAD_BEEF);
            chk($sformatf("bp_hold%0d_host_ready", c), host_req_ready, 32'd0);
        end
        @(negedge clk);
        cpu_rsp_ready = 1;
        #1;
        chk("bp_release_host_ready", host_req_ready, 32'd0);
        @(negedge clk); #1;
        chk("bp_host_grant", host_req_ready, 32'd1);
        @(negedge clk);
        host_req_valid = 0;
        @(negedge clk); #1;
        chk("bp_host_rsp", host_rsp_valid, 32'd1);
        chk("bp_host_rdata", host_rsp_rdata, 32'hA5A5_0001);
        drain("bp");

        // Reset during the ACCESS of a host write to 0x40.
        @(negedge clk);
        host_req_valid = 1; host_req_we = 1; host_req_addr = 32'h40; host_req_wdata = 32'h1122_3344;
        #1;
        chk("rst1_host_grant", host_req_ready, 32'd1);
        @(negedge clk);
        host_req_valid = 0;
        #1;
        chk("rst1_mem_write_before", mem_write, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("rst1_mem_write_drop", mem_write, 32'd0);
        chk("rst1_busy", busy, 32'd0);
        #1 reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            chk($sformatf("rst1_no_rsp%0d", c), host_rsp_valid | cpu_rsp_valid, 32'd0);
        end
        chk("rst1_mem_unchanged", mem_model[16], 32'h0);
        @(negedge clk);
        cpu_req_valid = 1; cpu_req_we = 0; cpu_req_addr = 32'h100;
        host_req_valid = 1; host_req_we = 0; host_req_addr = 32'h200;
        #1;
        chk("rst1_tie_cpu", cpu_req_ready, 32'd1);
        chk("rst1_tie_host", host_req_ready, 32'd0);
        @(negedge clk);
        cpu_req_valid = 0; host_req_valid = 0;
        drain("rst1");

        // Reset during RESP of a CPU read: the following tie must go back to the CPU.
        @(negedge clk);
        cpu_req_valid = 1; cpu_req_we = 0; cpu_req_addr = 32'h100; cpu_rsp_ready = 0;
        #1;
        chk("rst2_cpu_grant", cpu_req_ready, 32'd1);
        @(negedge clk);
        cpu_req_valid = 0;
        @(negedge clk); #1;
        chk("rst2_rsp_before", cpu_rsp_valid, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("rst2_rsp_drop", cpu_rsp_valid, 32'd0);
        #1 reset = 1'b0;
        cpu_rsp_ready = 1;
        @(negedge clk);
        cpu_req_valid = 1; host_req_valid = 1;
        #1;
        chk("rst2_tie_cpu", cpu_req_ready, 32'd1);
        chk("rst2_tie_host", host_req_ready, 32'd0);
        @(negedge clk);
        cpu_req_valid = 0; host_req_valid = 0;
        drain("rst2");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
